// File: rtl/demux1x4_stream_if.sv
// ---------------------------------------------------------------------------
// demux1x4_stream_if
// Bundles the input beat handshake, the four output channels and the
// per-channel delivered-beat counters of demux1x4_stream.
//   slave  : the demultiplexer itself (accepts beats, drives channels)
//   master : the environment (producer + four consumers + counter readers)
// Signals:
//   valid_i/ready_o/data_i/sel_i  input beat handshake, payload, destination
//   y0_o..y3_o, y_valid_o         registered payload and valid per channel
//   y_ready_i                     per-channel consumer ready
//   cnt_clr_i                     synchronous clear of all counters
//   cnt0_o..cnt3_o                saturating delivered-beat counters
// ---------------------------------------------------------------------------
interface demux1x4_stream_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             valid_i;
    logic             ready_o;
    logic [WIDTH-1:0] data_i;
    logic [1:0]       sel_i;
    logic [WIDTH-1:0] y0_o;
    logic [WIDTH-1:0] y1_o;
    logic [WIDTH-1:0] y2_o;
    logic [WIDTH-1:0] y3_o;
    logic [3:0]       y_valid_o;
    logic [3:0]       y_ready_i;
    logic             cnt_clr_i;
    logic [CNT_W-1:0] cnt0_o;
    logic [CNT_W-1:0] cnt1_o;
    logic [CNT_W-1:0] cnt2_o;
    logic [CNT_W-1:0] cnt3_o;

    modport slave (
        input  valid_i, data_i, sel_i, y_ready_i, cnt_clr_i,
        output ready_o, y0_o, y1_o, y2_o, y3_o, y_valid_o,
               cnt0_o, cnt1_o, cnt2_o, cnt3_o
    );

    modport master (
        output valid_i, data_i, sel_i, y_ready_i, cnt_clr_i,
        input  ready_o, y0_o, y1_o, y2_o, y3_o, y_valid_o,
               cnt0_o, cnt1_o, cnt2_o, cnt3_o
    );
endinterface

// File: rtl/demux1x4_stream.sv
// ---------------------------------------------------------------------------
// demux1x4_stream
// 1-to-4 stream demultiplexer. One beat per cycle is accepted on the input
// handshake and routed by sel_i into one of four one-entry holding registers,
// each with its own valid/ready handshake and saturating delivered-beat
// counter. A stalled channel only blocks beats addressed to it.
// Ports:
//   clk_i    clock, all state updates on the rising edge
//   rst_n_i  synchronous active-low reset (also gates ready_o)
//   bus      demux1x4_stream_if.slave: input handshake, four output
//            channels, counter clear and counters
// ---------------------------------------------------------------------------
module demux1x4_stream #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    demux1x4_stream_if.slave      bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       full_q;
    logic [3:0]       full_d;
    logic [WIDTH-1:0] data_q [4];
    logic [WIDTH-1:0] data_d [4];
    logic [CNT_W-1:0] cnt_q  [4];
    logic [CNT_W-1:0] cnt_d  [4];

    logic [3:0]       load;
    logic [3:0]       drain;
    logic             ready;
    logic             acc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    assign drain = full_q & bus.y_ready_i;

    // A channel can take a new beat if it is empty or is being drained in
    // this same cycle; only the addressed channel matters.
    assign ready = rst_n_i && (!full_q[bus.sel_i] || bus.y_ready_i[bus.sel_i]);
    assign acc   = bus.valid_i && ready;

    always_comb begin
        load   = '0;
        full_d = full_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        for (int k = 0; k < 4; k++) begin
            load[k] = acc && (bus.sel_i == 2'(k));
            // Load wins over drain so a channel can sustain one beat/cycle.
            if (load[k]) begin
                full_d[k] = 1'b1;
                data_d[k] = bus.data_i;
            end else if (drain[k]) begin
                full_d[k] = 1'b0;
            end
            // Clear has priority over a same-cycle delivery count.
            if (bus.cnt_clr_i) begin
                cnt_d[k] = '0;
            end else if (drain[k]) begin
                cnt_d[k] = sat_inc(cnt_q[k]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            full_q <= '0;
            data_q <= '{default: '0};
            cnt_q  <= '{default: '0};
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.ready_o   = ready;
    assign bus.y_valid_o = full_q;
    assign bus.y0_o      = data_q[0];
    assign bus.y1_o      = data_q[1];
    assign bus.y2_o      = data_q[2];
    assign bus.y3_o      = data_q[3];
    assign bus.cnt0_o    = cnt_q[0];
    assign bus.cnt1_o    = cnt_q[1];
    assign bus.cnt2_o    = cnt_q[2];
    assign bus.cnt3_o    = cnt_q[3];

endmodule

// File: doc/demux1x4_stream.md
Name: demux1x4_stream

Overview:
- 1-to-4 stream demultiplexer: the inverse of the team's 4x1 mux.
- Accepts one beat per cycle on a single valid/ready input and routes it, by a 2-bit select sent with the beat, to one of four registered output channels.
- Each output channel has its own one-entry holding register, own valid/ready handshake and a saturating delivered-beat counter.
- Sits between a single producer and four independent consumers; a stalled consumer blocks only beats addressed to it.

Parameters:
- WIDTH, 8, data width of the input beat and of each output channel.
- CNT_W, 16, width of each per-channel delivered-beat counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  synchronous active-low reset.
- valid_i  input  1  input beat valid.
- ready_o  output  1  input beat accepted when valid_i && ready_o.
- data_i  input  WIDTH  input beat payload.
- sel_i  input  2  destination channel of the input beat (0..3).
- y0_o, y1_o, y2_o, y3_o  output  WIDTH each  registered payload of channels 0..3.
- y_valid_o  output  4  bit k: channel k holds a beat.
- y_ready_i  input  4  bit k: consumer k accepts the beat this cycle.
- cnt_clr_i  input  1  synchronous clear of all counters.
- cnt0_o, cnt1_o, cnt2_o, cnt3_o  output  CNT_W each  beats delivered on channels 0..3.

Behaviour:
- Reset (rst_n_i=0 at clock edge):
  - y_valid_o=4'b0000; y0_o..y3_o=0; cnt0_o..cnt3_o=0.
  - ready_o is forced 0 combinationally while rst_n_i=0.
  - An in-flight beat is discarded; there is no partial delivery.
- Per-channel state k is full_k, reflected as y_valid_o[k]. Drain event: drain_k = full_k && y_ready_i[k].
- ready_o = rst_n_i && (!full[sel_i] || y_ready_i[sel_i]). It is combinational on sel_i and y_ready_i; no dependency on valid_i.
- Accept: acc = valid_i && ready_o. load_k = acc && (sel_i==k).
- Next state for each channel k:
  - load_k=1: full_k←1; yk_o←data_i. Covers a load and drain in the same cycle: the channel stays full with the new beat, giving full throughput of 1 beat/cycle per channel.
  - load_k=0 and drain_k=1: full_k←0; yk_o holds its last value.
  - Otherwise: unchanged.
- Latency:
  - A beat accepted at edge N appears on yk_o with y_valid_o[k]=1 from edge N until its handshake.
  - Minimum 1 cycle from input handshake to output visibility.
  - No combinational path from data_i to any yk_o.
- Output rule: while y_valid_o[k]=1 and y_ready_i[k]=0, yk_o must stay stable.
- Upstream rule: data_i and sel_i must be stable while valid_i && !ready_o. The block does not check this.
- Isolation: a full, stalled channel j never affects acceptance of beats with sel_i≠j. Beats for other channels are accepted in that same cycle.
- Counters:
  - cntk increments by 1 on drain_k and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr_i=1 zeroes all four counters and takes priority over a same-cycle increment. That drain is not counted.
  - cnt_clr_i does not affect data or valid state.
- Order: beats to the same channel are delivered in acceptance order. There is no ordering guarantee across channels.
- Mid-operation reset: when rst_n_i=0, full channels are emptied at that edge. y_valid_o=0 from the next cycle, regardless of y_ready_i.

Test Plan:
- Reset then send data 0xA5 sel=2 with all y_ready_i=0 -> ready_o=1 at the accept cycle. Next cycle y_valid_o=4'b0100, y2_o=0xA5. Other channels stay invalid.
- Channel 1 full and stalled (y_ready_i[1]=0), send sel=1 -> ready_o=0 and y1_o unchanged. Switch to sel=3 data 0x3C -> ready_o=1, y3_o=0x3C next cycle.
- Channel 0 with y_ready_i[0]=1 held, stream 0x01,0x02,0x03 back-to-back on sel=0 -> ready_o stays 1 every cycle. y0_o shows 0x01,0x02,0x03 on consecutive cycles; cnt0_o reaches 3.
- CNT_W=4, deliver 17 beats on channel 3 -> cnt3_o=15 (saturated). Pulse cnt_clr_i on the same cycle as a drain -> cnt3_o=0.
- All four channels full, assert rst_n_i=0 for one cycle -> y_valid_o=4'b0000, all data and counters 0, ready_o=0 during reset and 1 afterwards.
- Randomised per-channel y_ready_i throttling against a scoreboard -> per-channel order preserved, no loss or duplication, each cntk equals handshakes seen on channel k.
